// File: rtl/mix_columns_iter_pkg.sv
// Shared constants and GF(2^8) helpers for the iterative MixColumns stage.
`include "aes_defs.vh"

package mix_columns_iter_pkg;

  localparam logic [7:0] POLY_LO = `AES_POLY_LO;
  localparam logic [0:0] ST_IDLE = `AES_ST_IDLE;
  localparam logic [0:0] ST_RUN  = `AES_ST_RUN;

  // Coefficient j multiplies byte j in row 0; later rows rotate right.
  localparam logic [3:0][7:0] FWD_COEF = {`AES_FWD_C3, `AES_FWD_C2, `AES_FWD_C1, `AES_FWD_C0};
  localparam logic [3:0][7:0] INV_COEF = {`AES_INV_C3, `AES_INV_C2, `AES_INV_C1, `AES_INV_C0};

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? POLY_LO : 8'h00);
  endfunction

  // Shift-and-XOR multiply; with a constant k this folds to a few XOR trees.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] k);
    logic [7:0] acc;
    logic [7:0] p;
    acc = '0;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (k[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

endpackage

// File: rtl/aes_defs.vh
// Field constants and FSM state encodings shared by the AES round stages.
`ifndef AES_DEFS_VH
`define AES_DEFS_VH

// Low byte of the field polynomial 0x11B, folded in by xtime on MSB overflow
`define AES_POLY_LO 8'h1B

`define AES_FWD_C0 8'h02
`define AES_FWD_C1 8'h03
`define AES_FWD_C2 8'h01
`define AES_FWD_C3 8'h01

`define AES_INV_C0 8'h0E
`define AES_INV_C1 8'h0B
`define AES_INV_C2 8'h0D
`define AES_INV_C3 8'h09

`define AES_ST_IDLE 1'b0
`define AES_ST_RUN  1'b1

`endif

// File: rtl/mix_column_word.sv
// Combinational (Inv)MixColumns of one 32-bit column, row 0 in the top byte.
module mix_column_word
  import mix_columns_iter_pkg::*;
(
  input  logic [0:31] col_in,
  input  logic        decrypt,
  output logic [0:31] col_out
);

  logic [3:0][7:0] a;

  for (genvar j = 0; j < 4; j++) begin : g_byte
    assign a[j] = col_in[8*j +: 8];
  end

  for (genvar i = 0; i < 4; i++) begin : g_row
    logic [7:0] fwd;
    logic [7:0] inv;

    // Both directions use constant coefficients, then a byte-wide mux picks one.
    always_comb begin
      logic [1:0] idx;
      fwd = '0;
      inv = '0;
      idx = '0;
      for (int j = 0; j < 4; j++) begin
        idx = 2'(j - i);
        fwd = fwd ^ gf_mul(a[j], FWD_COEF[idx]);
        inv = inv ^ gf_mul(a[j], INV_COEF[idx]);
      end
    end

    assign col_out[8*i +: 8] = decrypt ? inv : fwd;
  end

endmodule

// File: rtl/mix_columns_iter.sv
// Iterative MixColumns: captures a 128-bit state, mixes one column per clock.
module mix_columns_iter
  import mix_columns_iter_pkg::*;
#(
  parameter int word_size  = 8,
  parameter int array_size = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         decrypt,
  input  logic [0:127] Data,
  output logic [0:127] Mixed_Data,
  output logic         done,
  output logic         busy
);

  localparam int         COL_W = 4 * word_size;
  localparam logic [1:0] LAST  = 2'(array_size / 4 - 1);

  logic [0:0]   state;
  logic [1:0]   col;
  logic [0:127] data_q;
  logic         dec_q;
  logic [0:31]  col_in;
  logic [0:31]  col_out;

  assign col_in = data_q[COL_W*col +: COL_W];

  mix_column_word u_mix (
    .col_in  (col_in),
    .decrypt (dec_q),
    .col_out (col_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      col        <= '0;
      data_q     <= '0;
      dec_q      <= 1'b0;
      Mixed_Data <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (en) begin
            data_q <= Data;
            dec_q  <= decrypt;
            col    <= '0;
            busy   <= 1'b1;
            state  <= ST_RUN;
          end
        end
        default: begin
          // Untouched columns keep the previous result until overwritten.
          Mixed_Data[COL_W*col +: COL_W] <= col_out;
          col <= col + 2'd1;
          if (col == LAST) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mix_columns_iter.sv
// Bench for mix_columns_iter: log/antilog GF model, per-cycle compare, directed vectors.
module tb_mix_columns_iter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         decrypt = 1'b0;
  logic [0:127] Data = '0;
  logic [0:127] Mixed_Data;
  logic         done;
  logic         busy;

  mix_columns_iter #(.word_size(8), .array_size(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .decrypt    (decrypt),
    .Data       (Data),
    .Mixed_Data (Mixed_Data),
    .done       (done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;
  int n_done   = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // GF(2^8) via log/antilog tables over generator 0x03
  int gexp[256];
  int glog[256];

  task automatic build_tables();
    int g;
    gexp[0] = 1;
    glog[1] = 0;
    for (int i = 1; i < 255; i++) begin
      g = gexp[i-1];
      gexp[i] = (g ^ ((g << 1) ^ (((g & 'h80) != 0) ? 'h11B : 0))) & 'hFF;
      glog[gexp[i]] = i;
    end
  endtask

  function automatic int gmul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return gexp[(glog[a] + glog[b]) % 255];
  endfunction

  function automatic logic [0:31] ref_col(input logic [0:31] c, input logic dec);
    int base[4];
    int b[4];
    int s;
    logic [0:31] r;
    if (dec) base = '{14, 11, 13, 9};
    else     base = '{2, 3, 1, 1};
    for (int j = 0; j < 4; j++) b[j] = int'(c[8*j +: 8]);
    r = '0;
    for (int i = 0; i < 4; i++) begin
      s = 0;
      for (int j = 0; j < 4; j++) s = s ^ gmul(base[(j - i + 4) % 4], b[j]);
      r[8*i +: 8] = 8'(s);
    end
    return r;
  endfunction

  function automatic logic [0:127] ref_block(input logic [0:127] d, input logic dec);
    logic [0:127] r;
    for (int c = 0; c < 4; c++) r[32*c +: 32] = ref_col(d[32*c +: 32], dec);
    return r;
  endfunction

  function automatic logic [0:127] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Timeline model: a whole result is computed at the start edge, then one
  // column is revealed per following edge.
  logic [0:127] m_out  = '0;
  logic [0:127] m_res  = '0;
  logic         m_done = 1'b0;
  logic         m_busy = 1'b0;
  int           m_ph   = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_out  = '0;
      m_done = 1'b0;
      m_busy = 1'b0;
      m_ph   = 0;
    end else begin
      m_done = 1'b0;
      if (m_ph == 0) begin
        if (en) begin
          m_res  = ref_block(Data, decrypt);
          m_ph   = 1;
          m_busy = 1'b1;
        end
      end else begin
        m_out[32*(m_ph-1) +: 32] = m_res[32*(m_ph-1) +: 32];
        if (m_ph == 4) begin
          m_ph   = 0;
          m_busy = 1'b0;
          m_done = 1'b1;
        end else begin
          m_ph++;
        end
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (!rst) begin
      chk("cyc_mixed", Mixed_Data, m_out);
      chk("cyc_done", 128'(done), 128'(m_done));
      chk("cyc_busy", 128'(busy), 128'(m_busy));
      if (done) n_done++;
    end
  end

  // Starts one block; poke>=0 re-asserts en with fresh Data at that RUN cycle.
  task automatic run_block(input logic [0:127] d, input logic dec, input int poke,
                           output logic [0:127] r, output int bcyc);
    bit got;
    @(negedge clk);
    Data = d; decrypt = dec; en = 1'b1;
    @(negedge clk);
    en = 1'b0; Data = rnd128(); decrypt = ~dec;
    bcyc = 0;
    got  = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      en = (i == poke);
      if (en) Data = rnd128();
      if (busy) bcyc++;
      if (done) got = 1'b1;
      else @(negedge clk);
    end
    en = 1'b0;
    if (!got) begin
      n_checks++; n_errs++;
      $display("FAIL block_timeout: no done within 10 cycles");
    end
    r = Mixed_Data;
  endtask

  logic [0:127] res, res2, orig;
  int bc;

  initial begin
    build_tables();
    #3;
    chk("rst_mixed", Mixed_Data, 128'h0);
    chk("rst_done", 128'(done), 128'h0);
    chk("rst_busy", 128'(busy), 128'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    chk("model_fwd0", 128'(ref_col(32'hdb135345, 1'b0)), 128'h8e4da1bc);
    chk("model_fwd1", 128'(ref_col(32'hf20a225c, 1'b0)), 128'h9fdc589d);
    chk("model_fwd2", 128'(ref_col(32'hd4d4d4d5, 1'b0)), 128'hd5d5d7d6);
    chk("model_fwd3", 128'(ref_col(32'h2d26314c, 1'b0)), 128'h4d7ebdf8);
    chk("model_inv0", 128'(ref_col(32'h8e4da1bc, 1'b1)), 128'hdb135345);

    run_block(128'hdb135345_01010101_01010101_01010101, 1'b0, -1, res, bc);
    chk("vec_single", res, 128'h8e4da1bc_01010101_01010101_01010101);
    chk("vec_single_busy", 128'(bc), 128'd4);

    run_block(128'hf20a225c_c6c6c6c6_d4d4d4d5_2d26314c, 1'b0, -1, res, bc);
    chk("vec_fips", res, 128'h9fdc589d_c6c6c6c6_d5d5d7d6_4d7ebdf8);

    run_block(128'h8e4da1bc_9fdc589d_c6c6c6c6_d5d5d7d6, 1'b1, -1, res, bc);
    chk("vec_inv", res, 128'hdb135345_f20a225c_c6c6c6c6_d4d4d4d5);

    // en during RUN must be dropped
    run_block(128'hf20a225c_c6c6c6c6_d4d4d4d5_2d26314c, 1'b0, 1, res, bc);
    chk("ignore_en_result", res, 128'h9fdc589d_c6c6c6c6_d5d5d7d6_4d7ebdf8);
    chk("ignore_en_busy", 128'(bc), 128'd4);

    // en held for 12 cycles with churning Data
    @(negedge clk);
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      en = 1'b1; Data = rnd128(); decrypt = 1'($urandom);
      @(negedge clk);
    end
    en = 1'b0;
    repeat (8) @(negedge clk);
    chk("held_en_dones", 128'(n_done), 128'd3);

    // Abort after the second column edge
    @(negedge clk);
    Data = rnd128(); decrypt = 1'b0; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_done = 0;
    rst = 1'b1;
    #1;
    chk("abort_mixed", Mixed_Data, 128'h0);
    chk("abort_busy", 128'(busy), 128'h0);
    chk("abort_done", 128'(done), 128'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_no_done", 128'(n_done), 128'd0);
    orig = rnd128();
    run_block(orig, 1'b0, -1, res, bc);
    chk("after_abort", res, ref_block(orig, 1'b0));

    for (int k = 0; k < 1000; k++) begin
      orig = rnd128();
      run_block(orig, 1'b0, -1, res, bc);
      run_block(res, 1'b1, -1, res2, bc);
      chk("roundtrip", res2, orig);
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
